// File: rtl/palindrome_pkg.sv
// Shared types and width helpers for the palindrome scheduler slice.
package palindrome_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESP
  } sched_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/palindrome_scheduler_if.sv
// Request and response channels between requester front-ends, the scheduler and the consumer.
interface palindrome_scheduler_if
  import palindrome_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_detect;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_detect
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_detect
  );

endinterface

// File: rtl/palindrome.sv
// Combinational palindrome checker: detection is high when the word equals its bit-reverse.
module palindrome #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  detection
);

  logic [DATA_WIDTH-1:0] reversed;

  always_comb begin
    reversed = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      reversed[i] = data[DATA_WIDTH-1-i];
    end
    detection = (data == reversed);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the caller owns the last_grant register.
module rr_arbiter
  import palindrome_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [id_width(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [id_width(NUM_REQ)-1:0] gnt_idx
);

  localparam int ID_W = id_width(NUM_REQ);

  logic found;

  // First pass covers indices above last_grant, second pass wraps around to the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && (ID_W'(i) > last_grant) && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && (ID_W'(i) <= last_grant) && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/palindrome_scheduler.sv
// Shares one palindrome checker among NUM_REQ requesters with round-robin arbitration
// and a valid/ready response channel; counts delivered palindromes with saturation.
module palindrome_scheduler
  import palindrome_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  palindrome_scheduler_if.slave bus,
  output logic [CNT_WIDTH-1:0] pal_count,
  output logic                 busy
);

  localparam int ID_W = id_width(NUM_REQ);

  sched_state_t          state;
  logic [DATA_WIDTH-1:0] word_q;
  logic [ID_W-1:0]       id_q;
  logic [ID_W-1:0]       last_grant;
  logic                  det_q;
  logic                  rsp_valid_q;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic [DATA_WIDTH-1:0] sel_word;
  logic                  detection;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  palindrome #(.DATA_WIDTH(DATA_WIDTH)) u_pal (
    .data      (word_q),
    .detection (detection)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_word = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gating with rst_n keeps the accept strobe quiet while reset is held.
  assign bus.req_ready  = (rst_n && (state == IDLE)) ? gnt : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_data   = word_q;
  assign bus.rsp_detect = det_q;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_q      <= '0;
      id_q        <= '0;
      det_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      pal_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            word_q <= sel_word;
            id_q   <= gnt_idx;
            state  <= CHECK;
          end
        end
        CHECK: begin
          det_q       <= detection;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_grant  <= id_q;
            state       <= IDLE;
            if (det_q && (pal_count != {CNT_WIDTH{1'b1}})) begin
              pal_count <= pal_count + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palindrome_scheduler.sv
// Scoreboard bench for palindrome_scheduler: expected responses are queued at stimulus time.
module tb_palindrome_scheduler;
  import palindrome_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          det;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  palindrome_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
  palindrome_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) sbus ();

  logic [CW-1:0] pal_count;
  logic          busy;
  logic [1:0]    s_pal_count;
  logic          s_busy;

  palindrome_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pal_count (pal_count),
    .busy      (busy)
  );

  palindrome_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sbus),
    .pal_count (s_pal_count),
    .busy      (s_busy)
  );

  exp_t          exp_q[$];
  int            grant_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          hold_all = 1'b0;
  logic [NR-1:0] drv_g;

  function automatic logic is_pal(input logic [DW-1:0] w);
    for (int i = 0; i < DW / 2; i++) begin
      if (w[i] !== w[DW-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] w);
    bus.req_valid[i]          = 1'b1;
    bus.req_data[i*DW +: DW]  = w;
  endtask

  task automatic push_exp(input int i, input logic [DW-1:0] w);
    exp_t e;
    e.id   = 2'(i);
    e.data = w;
    e.det  = is_pal(w);
    exp_q.push_back(e);
  endtask

  // Requester model: drops its request after the edge where it was accepted, logs grants.
  always @(posedge clk) begin
    drv_g = bus.req_ready;
    for (int i = 0; i < NR; i++) begin
      if (drv_g[i]) grant_q.push_back(i);
    end
    #1;
    if (!hold_all) bus.req_valid = bus.req_valid & ~drv_g;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect, busy} !== '0)
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect, busy});
    checks++;
    if (pal_count !== '0) $display("[TB] FAIL reset_pal_count: got %0d expected 0", pal_count);
    checks++;
    if (s_pal_count !== 2'd0) $display("[TB] FAIL reset_sat_count: got %0d expected 0", s_pal_count);
    errors += (({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect, busy} !== '0) ? 1 : 0)
            + ((pal_count !== '0) ? 1 : 0) + ((s_pal_count !== 2'd0) ? 1 : 0);
    rst_n   = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_single(input int id, input logic [DW-1:0] w);
    exp_t e;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    set_req(id, w);
    push_exp(id, w);
    #1;
    checks++;
    if (bus.req_ready !== 4'(1 << id)) begin
      errors++;
      $display("[TB] FAIL single_grant: got %b expected %b", bus.req_ready, 4'(1 << id));
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_check_phase: got valid=%b busy=%b expected valid=0 busy=1", bus.rsp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_latency: got rsp_valid=%b expected 1", bus.rsp_valid);
    end else begin
      e = exp_q.pop_front();
      if ({bus.rsp_id, bus.rsp_data, bus.rsp_detect} !== {e.id, e.data, e.det}) begin
        errors++;
        $display("[TB] FAIL single_rsp: got id=%0d data=%b det=%b expected id=%0d data=%b det=%b",
                 bus.rsp_id, bus.rsp_data, bus.rsp_detect, e.id, e.data, e.det);
      end
      if (e.det) exp_cnt++;
    end
    @(negedge clk);
    checks++;
    if (pal_count !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d expected %0d", pal_count, exp_cnt);
    end
  endtask

  task automatic test_round_robin();
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] words[NR] = '{8'h81, 8'h3C, 8'h12, 8'hFF};
    int   nrsp = 0;
    exp_t e;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n    = 1'b0;
    hold_all = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, words[i]);
    exp_q.delete();
    for (int k = 0; k < 5; k++) push_exp(exp_order[k], words[exp_order[k]]);
    repeat (2) @(negedge clk);
    grant_q.delete();
    exp_cnt = '0;
    rst_n   = 1'b1;
    for (int cyc = 0; cyc < 60 && nrsp < 5; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_data, bus.rsp_detect} !== {e.id, e.data, e.det}) begin
          errors++;
          $display("[TB] FAIL rr_rsp%0d: got id=%0d data=%h det=%b expected id=%0d data=%h det=%b",
                   nrsp, bus.rsp_id, bus.rsp_data, bus.rsp_detect, e.id, e.data, e.det);
        end
        if (e.det) exp_cnt++;
        nrsp++;
        if (nrsp == 5) begin
          hold_all      = 1'b0;
          bus.req_valid = '0;
        end
      end
    end
    checks++;
    if (nrsp != 5) begin
      errors++;
      $display("[TB] FAIL rr_timeout: got %0d responses expected 5", nrsp);
    end
    checks++;
    if (grant_q.size() != 5) begin
      errors++;
      $display("[TB] FAIL rr_grant_count: got %0d expected 5", grant_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (grant_q[k] != exp_order[k]) begin
          errors++;
          $display("[TB] FAIL rr_order%0d: got %0d expected %0d", k, grant_q[k], exp_order[k]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (pal_count !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d expected %0d", pal_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(1, 8'h81);
    set_req(3, 8'h0F);
    push_exp(1, 8'h81);
    push_exp(3, 8'h0F);
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid !== 1'b1 && n < 10);
    for (int k = 0; k < 5; k++) begin
      e = exp_q[0];
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect} !== {1'b1, e.id, e.data, e.det}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d data=%h det=%b expected v=1 id=%0d data=%h det=%b",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect, e.id, e.data, e.det);
      end
      checks++;
      if (bus.req_ready !== '0 || pal_count !== exp_cnt) begin
        errors++;
        $display("[TB] FAIL bp_quiet%0d: got ready=%b count=%0d expected ready=0 count=%0d",
                 k, bus.req_ready, pal_count, exp_cnt);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    e = exp_q.pop_front();
    if (e.det) exp_cnt++;
    n = 0;
    while (bus.rsp_valid === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_second_timeout: got rsp_valid=%b expected 1", bus.rsp_valid);
    end else begin
      e = exp_q.pop_front();
      if ({bus.rsp_id, bus.rsp_data, bus.rsp_detect} !== {e.id, e.data, e.det}) begin
        errors++;
        $display("[TB] FAIL bp_second_rsp: got id=%0d data=%h det=%b expected id=%0d data=%h det=%b",
                 bus.rsp_id, bus.rsp_data, bus.rsp_detect, e.id, e.data, e.det);
      end
      if (e.det) exp_cnt++;
    end
    @(negedge clk);
    checks++;
    if (pal_count !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d expected %0d", pal_count, exp_cnt);
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int   n = 0;
    int   got = 0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    set_req(1, 8'h00);
    push_exp(1, 8'h00);
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid !== 1'b1 && n < 10);
    e = exp_q.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect} !== {1'b1, e.id, e.data, e.det}) begin
      errors++;
      $display("[TB] FAIL midop_pre_rsp: got v=%b id=%0d data=%h expected v=1 id=%0d data=%h",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data);
    end
    @(negedge clk);
    set_req(2, 8'h99);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_in_check: got busy=%b valid=%b expected busy=1 valid=0", busy, bus.rsp_valid);
    end
    set_req(0, 8'hA5);
    set_req(2, 8'h99);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect, busy, pal_count} !== '0) begin
      errors++;
      $display("[TB] FAIL midop_async_reset: got ready=%b v=%b id=%0d data=%h det=%b busy=%b count=%0d expected all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_detect, busy, pal_count);
    end
    exp_cnt = '0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midop_no_rsp: got rsp_valid=%b expected 0", bus.rsp_valid);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midop_first_grant: got %b expected 0001", bus.req_ready);
    end
    push_exp(0, 8'hA5);
    push_exp(2, 8'h99);
    for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_data, bus.rsp_detect} !== {e.id, e.data, e.det}) begin
          errors++;
          $display("[TB] FAIL midop_rsp%0d: got id=%0d data=%h det=%b expected id=%0d data=%h det=%b",
                   got, bus.rsp_id, bus.rsp_data, bus.rsp_detect, e.id, e.data, e.det);
        end
        if (e.det) exp_cnt++;
        got++;
      end
    end
    checks++;
    if (got != 2) begin
      errors++;
      $display("[TB] FAIL midop_timeout: got %0d responses expected 2", got);
    end
    @(negedge clk);
    checks++;
    if (pal_count !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL midop_count: got %0d expected %0d", pal_count, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    int sat_tab[5] = '{1, 2, 3, 3, 3};
    int n;
    sbus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sbus.req_valid[0]  = 1'b1;
      sbus.req_data[7:0] = 8'h18;
      @(posedge clk);
      #1 sbus.req_valid = '0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (sbus.rsp_valid !== 1'b1 && n < 10);
      checks++;
      if ({sbus.rsp_valid, sbus.rsp_id, sbus.rsp_detect} !== {1'b1, 2'd0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL sat_rsp%0d: got v=%b id=%0d det=%b expected v=1 id=0 det=1",
                 k, sbus.rsp_valid, sbus.rsp_id, sbus.rsp_detect);
      end
      @(negedge clk);
      checks++;
      if (s_pal_count !== 2'(sat_tab[k])) begin
        errors++;
        $display("[TB] FAIL sat_count%0d: got %0d expected %0d", k, s_pal_count, sat_tab[k]);
      end
    end
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.rsp_ready  = 1'b1;
    sbus.req_valid = '0;
    sbus.req_data  = '0;
    sbus.rsp_ready = 1'b1;
    $display("[TB] starting palindrome_scheduler bench");
    test_reset();
    test_single(2, 8'b10100101);
    test_single(1, 8'b11110111);
    test_single(0, 8'b11111111);
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/palindrome_scheduler.md
# palindrome_scheduler

Shares one combinational `palindrome` checker among `NUM_REQ` requesters. Arbitrates pending words round-robin, captures the granted word, and registers the checker's `detection` result. Returns the result with the requester ID on a valid/ready response channel, and keeps a running count of palindromes found. Sits between the requester front-ends and the single shared checker instance.

## Interface
- `DATA_WIDTH`, 8: word width; passed to the checker.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `CNT_WIDTH`, 16: width of the palindrome counter.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester word pending.
- `req_data` input NUM_REQ*DATA_WIDTH: flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` output NUM_REQ: one-hot accept strobe.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts result.
- `rsp_id` output $clog2(NUM_REQ): index of the requester whose word was checked.
- `rsp_data` output DATA_WIDTH: the checked word.
- `rsp_detect` output 1: 1 when the word equals its bit-reverse.
- `pal_count` output CNT_WIDTH: number of palindromes delivered; saturates.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, CHECK, RESP.
- IDLE: if any `req_valid` is high, grant the first requester at or after `(last_grant+1) mod NUM_REQ`.
  - Assert that requester's `req_ready` in the same cycle (combinational from state and `req_valid`).
  - Latch its `req_data` into `word_q` and its index into `id_q`.
  - Go to CHECK.
- IDLE with no requests: stay in IDLE.
- CHECK: drive `word_q` into the checker, register `detection` into `det_q`, and go to RESP.
- RESP: hold `rsp_valid`=1 with `rsp_id`=`id_q`, `rsp_data`=`word_q`, `rsp_detect`=`det_q`.
  - When `rsp_ready`=1: if `det_q`=1 and `pal_count` is below all-ones, increment `pal_count`. Set `last_grant`=`id_q` and go to IDLE.
- Requests are never dropped. A requester holds `req_valid` and `req_data` until it sees its `req_ready`.
- `req_ready` is asserted only in IDLE, and only to the requester being granted.
- `pal_count` saturates at 2^CNT_WIDTH−1. It is never cleared except by reset.
- Reset mid-operation aborts any in-flight word with no response. State returns to IDLE.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_detect`=0, `pal_count`=0, `busy`=0.
  - `last_grant`=NUM_REQ−1, so requester 0 wins first after reset.

## Timing
- Accept in cycle T (IDLE, `req_ready` high). CHECK in T+1. `rsp_valid` rises in T+2.
- With `rsp_ready` held high, the response lasts one cycle and the next accept can happen at T+3. Peak throughput is one word per 3 cycles.
- Backpressure: RESP holds all `rsp_*` outputs stable for as long as `rsp_ready`=0.
- `pal_count` updates on the clock edge where the RESP handshake completes. The new value is visible at T+3 at the earliest.
- Simultaneous requests: exactly one is granted per IDLE cycle. A requester that is continuously pending is served within NUM_REQ transactions.
- `req_valid` deasserting in CHECK or RESP has no effect on the current transaction.

## Structure
- Package `palindrome_pkg` holds:
  - the state enum `sched_state_t` {IDLE, CHECK, RESP};
  - the `DATA_WIDTH` default;
  - the ID-width constant/function (`$clog2(NUM_REQ)`, minimum 1).
- Sub-module `rr_arbiter`: parameter `NUM_REQ`; inputs `req` and `last_grant`; outputs `gnt` (one-hot) and `gnt_idx`. Purely combinational; the scheduler owns the `last_grant` register.
- The existing `palindrome` module is instantiated once, fed by `word_q`.

## Test plan
- Single request: requester 2 presents 8'b10100101 with `rsp_ready`=1. `req_ready[2]` pulses. At T+2, `rsp_valid`=1, `rsp_id`=2, `rsp_detect`=1, and `pal_count` becomes 1.
- Non-palindrome: 8'b11110111 gives `rsp_detect`=0 and leaves `pal_count` unchanged. 8'b11111111 gives `rsp_detect`=1.
- Round-robin: all 4 requesters held valid from reset. Grants occur in order 0,1,2,3,0 and no requester is granted twice before all others have been granted.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP. Outputs stay stable, no `req_ready` is asserted, and `pal_count` increments exactly once after release.
- Reset mid-op: assert `rst_n`=0 during CHECK. All outputs return to their reset values asynchronously and no response is emitted. After release, requester 0 is granted first.
- Saturation: with `CNT_WIDTH`=2, deliver 5 palindromes. `pal_count` reads 1,2,3,3,3.
